// File: rtl/modexp_engine.sv
// Constant-time modular exponentiation (left-to-right square-and-multiply over a
// bit-serial modular multiplier). Optional macro: MODEXP_ZERO_MOD_CHECK_EN.
module modexp_engine #(
  parameter int WIDTH     = 32,
  parameter int EXP_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulus,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic                 err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int EW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [EW-1:0]    BIT_TOP  = EW'(EXP_WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1'b1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_REDUCE, S_SQR, S_MUL, S_DONE
  } state_t;

  state_t               state_r;
  logic [WIDTH-1:0]     base_r, q_r, acc_r, gr_r, mx_r, my_r, mr_r, result_r;
  logic [EXP_WIDTH-1:0] exp_r;
  logic [CW-1:0]        cnt_r;
  logic [EW-1:0]        bit_r;
  logic                 busy_r, done_r, err_r;

  logic [WIDTH:0]       dbl_s, red_s, add_s, sum_s, q_ext_s;
  logic [WIDTH-1:0]     step_s, one_q_s, nacc_s;
  logic                 last_s;

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;
  assign err    = err_r;

  // One multiplier step: r = 2r mod q, then r = r + x mod q when the current y bit is set
  always_comb begin
    q_ext_s = {1'b0, q_r};
    dbl_s   = {mr_r, 1'b0};
    red_s   = (dbl_s >= q_ext_s) ? (dbl_s - q_ext_s) : dbl_s;
    add_s   = red_s + {1'b0, mx_r};
    if (my_r[WIDTH-1]) begin
      sum_s = (add_s >= q_ext_s) ? (add_s - q_ext_s) : add_s;
    end else begin
      sum_s = red_s;
    end
    step_s  = sum_s[WIDTH-1:0];
    one_q_s = (q_r == ONE) ? {WIDTH{1'b0}} : ONE;
    last_s  = (cnt_r == CNT_LAST);
    nacc_s  = exp_r[bit_r] ? step_s : acc_r;
  end

  // Control FSM and datapath registers; every phase is WIDTH multiplier steps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      base_r   <= '0;
      q_r      <= '0;
      exp_r    <= '0;
      acc_r    <= '0;
      gr_r     <= '0;
      mx_r     <= '0;
      my_r     <= '0;
      mr_r     <= '0;
      cnt_r    <= '0;
      bit_r    <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= '0;
      err_r    <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            base_r  <= base;
            exp_r   <= exponent;
            q_r     <= modulus;
            busy_r  <= 1'b1;
            state_r <= S_INIT;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_INIT: begin
          acc_r   <= one_q_s;
          mx_r    <= one_q_s;
          my_r    <= base_r;
          mr_r    <= '0;
          cnt_r   <= '0;
          bit_r   <= BIT_TOP;
`ifdef MODEXP_ZERO_MOD_CHECK_EN
          state_r <= (q_r == {WIDTH{1'b0}}) ? S_DONE : S_REDUCE;
`else
          state_r <= S_REDUCE;
`endif
        end
        S_REDUCE, S_SQR, S_MUL: begin
          mr_r  <= step_s;
          my_r  <= my_r << 1;
          cnt_r <= cnt_r + CW'(1'b1);
          if (last_s) begin
            mr_r  <= '0;
            cnt_r <= '0;
            if (state_r == S_REDUCE) begin
              gr_r    <= step_s;
              mx_r    <= acc_r;
              my_r    <= acc_r;
              state_r <= S_SQR;
            end else if (state_r == S_SQR) begin
              acc_r   <= step_s;
              mx_r    <= gr_r;
              my_r    <= step_s;
              state_r <= S_MUL;
            end else begin
              // The product is always computed; the exponent bit only selects it
              acc_r <= nacc_s;
              mx_r  <= nacc_s;
              my_r  <= nacc_s;
              if (bit_r == {EW{1'b0}}) begin
                state_r <= S_DONE;
              end else begin
                bit_r   <= bit_r - EW'(1'b1);
                state_r <= S_SQR;
              end
            end
          end
        end
        S_DONE: begin
          if (!done_r) begin
            done_r   <= 1'b1;
            result_r <= (q_r == {WIDTH{1'b0}}) ? {WIDTH{1'b0}} : acc_r;
`ifdef MODEXP_ZERO_MOD_CHECK_EN
            err_r    <= (q_r == {WIDTH{1'b0}});
`else
            err_r    <= 1'b0;
`endif
          end else begin
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          err_r   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_engine.sv
// Directed self-checking bench for modexp_engine at WIDTH=8, EXP_WIDTH=4.
module tb_modexp_engine;

  localparam int W = 8;
  localparam int E = 4;
  localparam int LAT = 2 + W * (1 + 2 * E);

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] base;
  logic [E-1:0] exponent;
  logic [W-1:0] modulus;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         err;

  int n_assert = 0;
  int n_fail   = 0;

  modexp_engine #(.WIDTH(W), .EXP_WIDTH(E)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base), .exponent(exponent),
    .modulus(modulus), .busy(busy), .done(done), .result(result), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Counts edges until done is seen (sampled 1 time unit after each edge); -1 on timeout
  task automatic wait_done(output int cyc);
    bit found;
    found = 1'b0;
    cyc = 0;
    while (!found && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (done === 1'b1) found = 1'b1;
    end
    if (!found) cyc = -1;
  endtask

  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) cnt++;
    end
  endtask

  task automatic accept(input logic [W-1:0] b, input logic [E-1:0] e, input logic [W-1:0] q,
                        input string tag);
    @(negedge clk);
    base = b; exponent = e; modulus = q; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base = ~b; exponent = ~e; modulus = q + 8'd3;
    chk({tag, "_busy_accept"}, busy, 1);
  endtask

  task automatic run_op(input logic [W-1:0] b, input logic [E-1:0] e, input logic [W-1:0] q,
                        input logic [W-1:0] er, input logic ee, input int lat, input string tag);
    int cyc;
    accept(b, e, q, tag);
    wait_done(cyc);
    chk({tag, "_latency"}, cyc, lat);
    chk({tag, "_result"}, result, er);
    chk({tag, "_err"}, err, ee);
    chk({tag, "_busy_with_done"}, busy, 1);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_busy_fall"}, busy, 0);
    chk({tag, "_result_hold"}, result, er);
  endtask

  initial begin
    int cyc;
    int nd;
    rst_n = 1'b0; start = 1'b0; base = '0; exponent = '0; modulus = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_err", err, 0);
    @(negedge clk); rst_n = 1'b1;

    // 3^5 = 243 = 34*7 + 5
    run_op(8'd3, 4'd5, 8'd7, 8'd5, 1'b0, LAT, "g3e5q7");
    // 5^4 = 625 = 89*7 + 2
    run_op(8'd5, 4'd4, 8'd7, 8'd2, 1'b0, LAT, "g5e4q7");
    // base above modulus: 12 mod 7 = 5
    run_op(8'd12, 4'd1, 8'd7, 8'd5, 1'b0, LAT, "g12e1q7");
    run_op(8'd9, 4'd0, 8'd7, 8'd1, 1'b0, LAT, "e0q7");
    run_op(8'd9, 4'd0, 8'd1, 8'd0, 1'b0, LAT, "e0q1");
    // 255 mod 251 = 4; 4^15 = 2^30; 2^8 = 5 mod 251 -> 5^3*64 = 8000 = 31*251 + 219
    run_op(8'd255, 4'd15, 8'd251, 8'd219, 1'b0, LAT, "g255e15q251");

    // Restart attempt mid-run must be ignored
    accept(8'd3, 4'd5, 8'd7, "overlap");
    repeat (9) @(posedge clk);
    @(negedge clk);
    start = 1'b1; base = 8'd2; exponent = 4'd3; modulus = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    chk("overlap_busy_held", busy, 1);
    wait_done(cyc);
    chk("overlap_latency", (cyc < 0) ? -1 : cyc + 10, LAT);
    chk("overlap_result", result, 5);
    count_dones(100, nd);
    chk("overlap_single_done", nd, 0);

    // Asynchronous reset mid-run
    accept(8'd5, 4'd4, 8'd7, "abort");
    repeat (29) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_err", err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    count_dones(100, nd);
    chk("abort_no_done", nd, 0);
    run_op(8'd3, 4'd5, 8'd7, 8'd5, 1'b0, LAT, "after_abort");

`ifdef MODEXP_ZERO_MOD_CHECK_EN
    run_op(8'd9, 4'd3, 8'd0, 8'd0, 1'b1, 2, "q0");
`else
    run_op(8'd9, 4'd3, 8'd0, 8'd0, 1'b0, LAT, "q0");
`endif
    // Back-to-back start on the first idle cycle
    run_op(8'd2, 4'd3, 8'd5, 8'd3, 1'b0, LAT, "g2e3q5");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/modexp_engine.md
MODEXP_ENGINE -- requirements
Module: modexp_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 32: bit width of base, modulus and result.
REQ-002 SHALL have parameter EXP_WIDTH, default 32: bit width of exponent.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request; sampled only while busy=0.
REQ-006 SHALL have port base  input  WIDTH  base g; any value, reduced internally.
REQ-007 SHALL have port exponent  input  EXP_WIDTH  exponent e.
REQ-008 SHALL have port modulus  input  WIDTH  modulus q.
REQ-009 SHALL have port busy  output  1  high from the cycle after start is accepted through the cycle done is high.
REQ-010 SHALL have port done  output  1  one-cycle pulse; result is valid.
REQ-011 SHALL have port result  output  WIDTH  g^e mod q.
REQ-012 SHALL have port err  output  1  modulus-zero flag, valid while done=1.

Function
REQ-013 SHALL capture base, exponent and modulus into internal registers on the edge where start=1 and busy=0; later input changes SHALL NOT affect the operation.
REQ-014 SHALL ignore start while busy=1, with no queuing.
REQ-015 SHALL implement FSM IDLE -> REDUCE -> SQR -> MUL -> (SQR, or DONE after exponent LSB) -> IDLE.
REQ-016 SHALL perform each modular multiply r = x*y mod q bit-serially, y MSB first, one bit per cycle: r = 2r mod q, then r = r + x mod q when the bit is 1; WIDTH cycles per multiply.
REQ-017 SHALL hold intermediates in WIDTH+1 bits and apply at most one conditional subtraction of q per step, so r < q always holds.
REQ-018 REDUCE SHALL compute gr = base mod q as the multiply 1*base mod q, and SHALL initialise acc = 1 mod q (acc = 0 when q=1).
REQ-019 SHALL scan the exponent left-to-right from bit EXP_WIDTH-1: SQR computes acc = acc*acc mod q; MUL computes t = acc*gr mod q; acc takes t only when the exponent bit is 1.
REQ-020 Both SQR and MUL SHALL run for every exponent bit, giving constant-time operation independent of exponent and base values.
REQ-021 done SHALL rise exactly 2 + WIDTH*(1 + 2*EXP_WIDTH) cycles after the accepting edge; busy SHALL fall together with done.
REQ-022 result SHALL update only in the cycle done rises, and SHALL hold that value until the next done.
REQ-023 exponent = 0 SHALL yield result = 1 mod q.
REQ-024 The same-cycle done and start SHALL NOT be accepted; start is accepted from the first cycle busy=0.

Reset
REQ-025 rst_n=0 SHALL asynchronously force FSM=IDLE, busy=0, done=0, err=0, result=0, and clear all internal registers.
REQ-026 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL be accepted normally.

Configuration
REQ-027 With macro MODEXP_ZERO_MOD_CHECK_EN defined, modulus=0 SHALL skip computation: done and err pulse together 2 cycles after the accepting edge, with result=0.
REQ-028 Without MODEXP_ZERO_MOD_CHECK_EN, err SHALL be constant 0; modulus=0 SHALL run full latency and return result=0.

Verification
REQ-029 WIDTH=8, EXP_WIDTH=4, base=3, exponent=5, modulus=7, start pulse -> done exactly 74 cycles later, result=5, err=0.
REQ-030 Same parameters, base=5, exponent=4, modulus=7 -> result=2; then base=12, exponent=1, modulus=7 -> result=5 (reduction check).
REQ-031 exponent=0, modulus=7 -> result=1; exponent=0, modulus=1 -> result=0; both at 74-cycle latency.
REQ-032 start re-pulsed and inputs changed at cycle 10 of a run -> no effect on the first result; busy stays high; exactly one done.
REQ-033 rst_n low at cycle 30 of a run -> busy, done, result and err 0 immediately; no done pulse; the next start returns the correct value.
REQ-034 modulus=0 with the macro defined -> done=1, err=1, result=0 at 2 cycles; without the macro -> err=0, result=0 at 74 cycles.
